// File: rtl/audio_i2s_tx.sv
// audio_i2s_tx: I2S master transmitter fed by a stream-side sample FIFO.
// Each 32-slot frame carries one 32-bit word: left sample [31:16], right sample [15:0].
module audio_i2s_tx #(
   parameter int FIFO_DEPTH = 8,
   parameter int BCLK_DIV   = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          enable,
   input  logic [31:0]                   s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   input  logic                          s_axis_tlast,
   output logic                          i2s_bclk,
   output logic                          i2s_lrclk,
   output logic                          i2s_dout,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(BCLK_DIV + 1);
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   level;
   logic [CW-1:0] div_cnt;
   logic [4:0]    slot, nslot;
   logic [31:0]   frame;
   logic          wrap, fall, load, push, pop;
   logic          unused_tlast;
   assign unused_tlast  = s_axis_tlast;
   assign nslot         = slot + 5'd1;
   assign wrap          = div_cnt == CW'(BCLK_DIV - 1);
   assign fall          = wrap && i2s_bclk;
   assign load          = fall && nslot == 5'd0;
   assign s_axis_tready = !rst && enable && level < (AW+1)'(FIFO_DEPTH);
   assign push          = s_axis_tvalid && s_axis_tready;
   assign pop           = load && level != '0;
   assign fifo_level    = level;
   always_ff @(posedge clk)
      if (push) mem[wptr] <= s_axis_tdata;
   // Disable behaves exactly like reset, so re-enable always restarts a clean frame.
   always_ff @(posedge clk) begin
      if (rst || !enable) begin
         wptr      <= '0;
         rptr      <= '0;
         level     <= '0;
         div_cnt   <= '0;
         i2s_bclk  <= 1'b0;
         slot      <= 5'd31;
         i2s_lrclk <= 1'b0;
         i2s_dout  <= 1'b0;
         frame     <= '0;
         underrun  <= 1'b0;
      end else begin
         div_cnt  <= wrap ? '0 : div_cnt + 1'b1;
         underrun <= load && level == '0;
         if (wrap) i2s_bclk <= !i2s_bclk;
         // Slot k sends frame[32-k]; slot 0 maps to bit 0 of the outgoing frame (one-bit delay).
         if (fall) begin
            slot      <= nslot;
            i2s_lrclk <= nslot[4];
            i2s_dout  <= frame[5'd0 - nslot];
         end
         if (load) frame <= pop ? mem[rptr] : '0;
         if (push) wptr <= wptr + 1'b1;
         if (pop) rptr <= rptr + 1'b1;
         level <= level + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
endmodule

// File: doc/audio_i2s_tx.md
AUDIO_I2S_TX -- requirements
Module: audio_i2s_tx

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8: sample FIFO entries, power of two, 2..64.
REQ-002 SHALL have parameter BCLK_DIV, default 4: clk cycles per BCLK half-period, 1..255.
REQ-003 SHALL use a single clock and synchronous active-high reset (already decided), with ports as listed below.
REQ-004 SHALL have port clk, input, 1 bit: sole clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port enable, input, 1 bit: transmitter run control.
REQ-007 SHALL have port s_axis_tdata, input, 32 bits: [31:16] left sample, [15:0] right sample, two's complement.
REQ-008 SHALL have port s_axis_tvalid, input, 1 bit: sample word valid.
REQ-009 SHALL have port s_axis_tready, output, 1 bit: FIFO can accept a word.
REQ-010 SHALL have port s_axis_tlast, input, 1 bit: ignored.
REQ-011 SHALL have port i2s_bclk, output, 1 bit: bit clock, master mode.
REQ-012 SHALL have port i2s_lrclk, output, 1 bit: word select; 0 = left, 1 = right.
REQ-013 SHALL have port i2s_dout, output, 1 bit: serial data.
REQ-014 SHALL have port fifo_level, output, $clog2(FIFO_DEPTH)+1 bits: current FIFO occupancy.
REQ-015 SHALL have port underrun, output, 1 bit: one-clk pulse when a frame load finds the FIFO empty.

Function
REQ-016 SHALL assert s_axis_tready = enable && (fifo_level < FIFO_DEPTH); handshake = tvalid && tready, one word accepted per clk.
REQ-017 SHALL apply a push and a pop in the same clk simultaneously, leaving fifo_level unchanged; a full FIFO SHALL never overwrite, and an empty FIFO SHALL never be popped.
REQ-018 SHALL run, while enable=1, a divider counting 0..BCLK_DIV-1 that toggles i2s_bclk on each wrap; while enable=0 the divider SHALL be held at 0.
REQ-019 SHALL use a 5-bit slot counter that advances on each BCLK falling edge (the clk on which i2s_bclk goes 1->0), wrapping 31->0.
REQ-020 SHALL drive i2s_lrclk low in slots 0..15 and high in slots 16..31, updated on the falling edge that enters the slot.
REQ-021 SHALL, on the falling edge entering slot 0, load frame register F from the FIFO head and pop it; if the FIFO is empty, F SHALL be loaded with 0 and underrun pulsed for that clk.
REQ-022 SHALL drive i2s_dout, per I2S one-bit delay: slot 0 = previous F[0]; slot k (1..31) = F[32-k], i.e. MSB-first with the left MSB in slot 1 and the right MSB in slot 17.
REQ-023 SHALL change i2s_dout and i2s_lrclk only on BCLK falling edges, so both are stable at every rising edge.
REQ-024 SHALL, on enable 0->1, hold the slot counter at 31 with i2s_bclk=0, so the first rising edge occurs BCLK_DIV clk after enable is sampled high and the first falling edge, at 2·BCLK_DIV, loads frame 0.
REQ-025 SHALL, on enable 1->0 (including mid-frame), on the next clk: flush the FIFO (level 0), set i2s_bclk=0, i2s_lrclk=0, i2s_dout=0, slot=31, F=0; no underrun pulse.
REQ-026 SHALL report fifo_level as a registered value reflecting pushes and pops of the previous clk.

Reset
REQ-027 SHALL, while rst=1, set: FIFO empty, fifo_level=0, s_axis_tready=0, i2s_bclk=0, i2s_lrclk=0, i2s_dout=0, underrun=0, divider=0, slot=31, F=0.
REQ-028 SHALL give rst priority over enable and over any handshake in the same clk; a word presented during reset SHALL be dropped.
REQ-029 SHALL treat the first clk after rst deasserts with enable=1 as enable being sampled high (REQ-024 timing).

Verification
REQ-030 SHALL verify basic frame: BCLK_DIV=2, push 0xA5A5_0F0F then enable -> lrclk low for 16 BCLKs, then high for 16; dout slots 1..16 = 1010010110100101, slots 17..32 = 0000111100001111.
REQ-031 SHALL verify underrun: enable with the FIFO empty -> underrun pulses once per frame (every 64·BCLK_DIV clk), dout all 0, BCLK keeps running.
REQ-032 SHALL verify backpressure: hold tvalid=1 with enable=1 -> tready drops after 8 accepts, fifo_level=8; tready reasserts the clk after the frame-load pop.
REQ-033 SHALL verify mid-frame disable: enable=0 at slot 10 with 3 words queued -> next clk fifo_level=0 and bclk/lrclk/dout=0; after re-enable, frame 0 is zeros with an underrun pulse.
REQ-034 SHALL verify reset mid-operation: rst=1 for 1 clk during slot 20 -> all outputs per REQ-027; after release, the first falling edge occurs 2·BCLK_DIV clk later.
REQ-035 SHALL verify simultaneous push/pop: FIFO at 1 word, push on the frame-load clk -> fifo_level stays 1 and the pushed word is sent in the next frame.
